// File: rtl/pwm_pkg.sv
// Shared types and defaults for the tick-driven PWM generator.
package pwm_pkg;

    localparam int PWM_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_generator_rise_detect.sv
// Rising-edge detector for a clk-synchronous level; emits a one-clk tick.
// The history register resets high so a level already high at reset release is not a tick.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic tick_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign tick_o = sig_i & ~sig_q;

endmodule

// File: rtl/pwm_generator.sv
// PWM generator advanced by divider ticks; period/duty are double-buffered and
// only swapped in at a period wrap while running.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             div_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  logic             load,
    output logic             pwm_out,
    output logic             cycle_done,
    output logic             load_pending,
    output logic [WIDTH-1:0] count
);

    logic tick;

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_a_q, period_a_d;
    logic [WIDTH-1:0] duty_a_q, duty_a_d;
    logic [WIDTH-1:0] period_s_q, period_s_d;
    logic [WIDTH-1:0] duty_s_q, duty_s_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             cycle_done_q, cycle_done_d;
    logic             wrap;

    rise_detect u_rise_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (div_in),
        .tick_o  (tick)
    );

    assign wrap = tick && (count_q == period_a_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        period_a_d   = period_a_q;
        duty_a_d     = duty_a_q;
        period_s_d   = period_s_q;
        duty_s_d     = duty_s_q;
        pending_d    = pending_q;
        cycle_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Nothing is running, so a load can go straight to the active set.
                if (load) begin
                    period_a_d = period;
                    duty_a_d   = duty;
                    pending_d  = 1'b0;
                end
                if (enable) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (wrap) begin
                    count_d      = '0;
                    cycle_done_d = 1'b1;
                    // A load coinciding with the wrap bypasses the shadow entirely.
                    if (load) begin
                        period_a_d = period;
                        duty_a_d   = duty;
                        pending_d  = 1'b0;
                    end else if (pending_q) begin
                        period_a_d = period_s_q;
                        duty_a_d   = duty_s_q;
                        pending_d  = 1'b0;
                    end
                end else begin
                    if (tick) begin
                        count_d = count_q + WIDTH'(1);
                    end
                    if (load) begin
                        period_s_d = period;
                        duty_s_d   = duty;
                        pending_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        pwm_d = (state_d == RUN) && (count_d < duty_a_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            period_a_q   <= '0;
            duty_a_q     <= '0;
            period_s_q   <= '0;
            duty_s_q     <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_a_q   <= period_a_d;
            duty_a_q     <= duty_a_d;
            period_s_q   <= period_s_d;
            duty_s_q     <= duty_s_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign cycle_done   = cycle_done_q;
    assign load_pending = pending_q;
    assign count        = count_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed scenarios plus random stimulus,
// all compared against an event-level reference model of the PWM rules.
module tb_pwm_generator;

    localparam int W  = 8;
    localparam int VW = W + 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         div_in = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] duty = '0;
    logic         pwm_out;
    logic         cycle_done;
    logic         load_pending;
    logic [W-1:0] count;

    int checks = 0;
    int errors = 0;
    bit div_auto = 1'b0;
    int div_ph = 0;

    // Reference model state
    bit m_run, m_prev, m_cd, m_pend;
    int m_cnt, m_per, m_duty, m_sp, m_sd;

    pwm_generator #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .div_in       (div_in),
        .enable       (enable),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .pwm_out      (pwm_out),
        .cycle_done   (cycle_done),
        .load_pending (load_pending),
        .count        (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_run = 0; m_prev = 1; m_cd = 0; m_pend = 0;
        m_cnt = 0; m_per = 0; m_duty = 0; m_sp = 0; m_sd = 0;
    endtask

    task automatic model_update();
        bit tk;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tk = div_in && !m_prev;
        m_prev = div_in;
        m_cd = 0;
        if (!m_run) begin
            if (load) begin m_per = int'(period); m_duty = int'(duty); m_pend = 0; end
            if (enable) begin m_run = 1; m_cnt = 0; end
        end else if (!enable) begin
            m_run = 0; m_cnt = 0;
        end else if (tk && m_cnt == m_per) begin
            m_cnt = 0; m_cd = 1;
            if (load) begin m_per = int'(period); m_duty = int'(duty); m_pend = 0; end
            else if (m_pend) begin m_per = m_sp; m_duty = m_sd; m_pend = 0; end
        end else begin
            if (tk) m_cnt = m_cnt + 1;
            if (load) begin m_sp = int'(period); m_sd = int'(duty); m_pend = 1; end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {(m_run && (m_cnt < m_duty)), m_cd, m_pend, W'(m_cnt)};
    endfunction

    function automatic bit tick_next();
        int nph;
        nph = div_ph + 1;
        return div_auto && (nph[1] == 1'b1) && !m_prev;
    endfunction

    task automatic step();
        if (div_auto) begin
            div_ph = div_ph + 1;
            div_in = div_ph[1];
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        checks++; if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_cd: got %b expected 0", cycle_done); end
        checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", load_pending); end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL reset_idle cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int last_cd, maxc;
        div_auto = 1'b1;
        period = 8'd3; duty = 8'd2; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        last_cd = -1; maxc = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL basic cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (cycle_done === 1'b1) begin
                if (last_cd >= 0) begin
                    checks++;
                    if (i - last_cd != 16) begin errors++; $display("FAIL basic_cd_gap: got %0d clk expected 16", i - last_cd); end
                end
                last_cd = i;
            end
        end
        checks++; if (maxc != 3) begin errors++; $display("FAIL basic_max_count: got %0d expected 3", maxc); end
    endtask

    task automatic test_deferred_load();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL defer_wait cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
            if (count === 8'd1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL defer_timeout: count=1 got not seen expected seen"); end
        period = 8'd1; duty = 8'd1; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL defer_pending: got %b expected 1", load_pending); end
        for (int i = 0; i < 48; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL defer cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
        end
        checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL defer_cleared: got %b expected 0", load_pending); end
    endtask

    task automatic test_edges();
        int pers[3] = '{3, 3, 0};
        int dts[3]  = '{0, 9, 1};
        int highs, lows, cds, tks;
        for (int c = 0; c < 3; c++) begin
            enable = 1'b0;
            step();
            period = W'(pers[c]); duty = W'(dts[c]); load = 1'b1;
            step();
            load = 1'b0; enable = 1'b1;
            step();
            highs = 0; lows = 0; cds = 0; tks = 0;
            for (int i = 0; i < 56; i++) begin
                if (tick_next()) tks++;
                step();
                checks++;
                if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                    errors++; $display("FAIL edge%0d cyc%0d: got %h expected %h", c, i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
                end
                if (pwm_out === 1'b1) highs++; else lows++;
                if (cycle_done === 1'b1) cds++;
            end
            checks++;
            if (c == 0 && highs != 0) begin errors++; $display("FAIL edge_duty0: got %0d high cycles expected 0", highs); end
            else if (c != 0 && lows != 0) begin errors++; $display("FAIL edge%0d_always_high: got %0d low cycles expected 0", c, lows); end
            if (c == 2) begin
                checks++;
                if (cds != tks) begin errors++; $display("FAIL edge_period0_cd: got %0d pulses expected %0d", cds, tks); end
            end
        end
    endtask

    task automatic test_load_at_wrap();
        bit done = 1'b0;
        int gap, highs;
        enable = 1'b0;
        step();
        period = 8'd3; duty = 8'd2; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (tick_next() && m_run && m_cnt == m_per && i > 20) begin
                period = 8'd5; duty = 8'd4; load = 1'b1; done = 1'b1;
            end
            step();
            load = 1'b0;
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL lwrap cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL lwrap_timeout: wrap got not found expected found"); end
        checks++; if (cycle_done !== 1'b1) begin errors++; $display("FAIL lwrap_cd: got %b expected 1", cycle_done); end
        gap = 0; highs = 0;
        for (int i = 1; i <= 40 && gap == 0; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL lwrap_next cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
            checks++;
            if (load_pending !== 1'b0) begin errors++; $display("FAIL lwrap_pending cyc%0d: got 1 expected 0", i); end
            if (pwm_out === 1'b1) highs++;
            if (cycle_done === 1'b1) gap = i;
        end
        checks++; if (gap != 24) begin errors++; $display("FAIL lwrap_period: got %0d clk expected 24", gap); end
        checks++; if (highs != 16) begin errors++; $display("FAIL lwrap_duty: got %0d high clk expected 16", highs); end
    endtask

    task automatic test_disable();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL dis_wait cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
            if (count === 8'd2) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL dis_timeout: count=2 got not seen expected seen"); end
        enable = 1'b0;
        step();
        checks++;
        if ({count, pwm_out, cycle_done} !== '0) begin
            errors++; $display("FAIL dis_idle: got count=%0d pwm=%b cd=%b expected 0/0/0", count, pwm_out, cycle_done);
        end
        for (int i = 0; i < 8 && !tick_next(); i++) step();
        enable = 1'b1;
        step();
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL dis_reenable_tick: got %0d expected 0", count); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL dis_run cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        int cds = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (count === 8'd3) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL arst_timeout: count=3 got not seen expected seen"); end
        div_auto = 1'b0; div_in = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pwm_out, cycle_done, load_pending, count} !== '0) begin
            errors++; $display("FAIL arst_async: got %h expected 0", {pwm_out, cycle_done, load_pending, count});
        end
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL arst_release cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
            if (cycle_done === 1'b1) cds++;
        end
        checks++; if (cds != 0) begin errors++; $display("FAIL arst_spurious_tick: got %0d pulses expected 0", cds); end
        div_in = 1'b0;
        step();
        div_in = 1'b1;
        step();
        checks++; if (cycle_done !== 1'b1) begin errors++; $display("FAIL arst_first_tick: got %b expected 1", cycle_done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            div_in = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 9) == 0);
            period = W'($urandom_range(0, 5));
            duty = W'($urandom_range(0, 7));
            step();
            checks++;
            if ({pwm_out, cycle_done, load_pending, count} !== exp_vec()) begin
                errors++; $display("FAIL random cyc%0d: got %h expected %h", i, {pwm_out, cycle_done, load_pending, count}, exp_vec());
            end
        end
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_deferred_load();
        test_edges();
        test_load_at_wrap();
        test_disable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
